// File: rtl/uart_rx_deserializer.sv
// UART receiver: 2-flop synchronized line, 8N1 framing, one-byte output
// register with valid/ready, and pulsed frame / overrun (and parity) errors.
//
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   uart_rx_i      serial line (async, idles high)
//   cdiv_i         clk_i cycles per bit (values below 4 behave as 4)
//   data_o/valid_o received byte, held until valid_o && ready_i
//   ready_i        consumer accept
//   frame_err_o    1-cycle pulse, stop bit sampled low
//   overrun_o      1-cycle pulse, byte dropped because output was full
//   parity_err_o   1-cycle pulse, only with UART_RX_PARITY_EN
//   busy_o         receiver is inside a frame
//
// Build option: define UART_RX_PARITY_EN for 8E1 frames (even parity).
module uart_rx_deserializer (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        uart_rx_i,
   input  logic [15:0] cdiv_i,
   output logic [7:0]  data_o,
   output logic        valid_o,
   input  logic        ready_i,
   output logic        frame_err_o,
   output logic        overrun_o,
`ifdef UART_RX_PARITY_EN
   output logic        parity_err_o,
`endif
   output logic        busy_o
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
   localparam logic [2:0] S_PARITY = 3'd3;
`endif
   localparam logic [2:0] S_STOP   = 3'd4;

   logic [1:0]  sync_q;
   logic [1:0]  fill_q;
   logic        prev_q;
   logic        rx_s;
   logic        fall;

   logic [2:0]  state_q;
   logic [15:0] cnt_q;
   logic [15:0] cdiv_q;
   logic [15:0] cdiv_eff;
   logic [2:0]  bit_q;
   logic [7:0]  shift_q;
   logic        tick_half;
   logic        tick_full;
   logic        stop_smp;
   logic        par_ok;
   logic        accept;
   logic        take;

   assign rx_s = sync_q[1];

   // fill_q marks when sync_q holds real line samples rather than reset
   // ones; until then prev_q stays 0 so a line held low out of reset
   // cannot look like a falling edge.
   assign fall = prev_q & ~rx_s;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q <= 2'b11;
         fill_q <= 2'b00;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[0], uart_rx_i};
         fill_q <= {fill_q[0], 1'b1};
         prev_q <= rx_s & fill_q[1];
      end
   end

   assign cdiv_eff  = (cdiv_i < 16'd4) ? 16'd4 : cdiv_i;
   assign tick_half = cnt_q == ({1'b0, cdiv_q[15:1]} - 16'd1);
   assign tick_full = cnt_q == (cdiv_q - 16'd1);
   assign stop_smp  = (state_q == S_STOP) && tick_full;
   assign busy_o    = state_q != S_IDLE;

`ifdef UART_RX_PARITY_EN
   logic par_q;
   assign par_ok = ~(^shift_q ^ par_q);
`else
   assign par_ok = 1'b1;
`endif

   assign accept = stop_smp & rx_s & par_ok;
   assign take   = accept & (~valid_o | ready_i);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         cnt_q       <= 16'd0;
         cdiv_q      <= 16'd0;
         bit_q       <= 3'd0;
         shift_q     <= 8'h00;
         data_o      <= 8'h00;
         valid_o     <= 1'b0;
         frame_err_o <= 1'b0;
         overrun_o   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_q        <= 1'b0;
         parity_err_o <= 1'b0;
`endif
      end else begin
         frame_err_o <= stop_smp & ~rx_s;
         overrun_o   <= accept & valid_o & ~ready_i;
`ifdef UART_RX_PARITY_EN
         parity_err_o <= stop_smp & rx_s & ~par_ok;
`endif
         if (take) begin
            data_o  <= shift_q;
            valid_o <= 1'b1;
         end else if (valid_o && ready_i) begin
            valid_o <= 1'b0;
         end

         unique case (state_q)
            S_IDLE: begin
               if (fall) begin
                  state_q <= S_START;
                  cnt_q   <= 16'd0;
                  cdiv_q  <= cdiv_eff;
               end
            end
            S_START: begin
               if (tick_half) begin
                  cnt_q   <= 16'd0;
                  bit_q   <= 3'd0;
                  state_q <= rx_s ? S_IDLE : S_DATA;
               end else begin
                  cnt_q <= cnt_q + 16'd1;
               end
            end
            S_DATA: begin
               if (tick_full) begin
                  cnt_q   <= 16'd0;
                  shift_q <= {rx_s, shift_q[7:1]};
                  bit_q   <= bit_q + 3'd1;
                  if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                     state_q <= S_PARITY;
`else
                     state_q <= S_STOP;
`endif
                  end
               end else begin
                  cnt_q <= cnt_q + 16'd1;
               end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
               if (tick_full) begin
                  cnt_q   <= 16'd0;
                  par_q   <= rx_s;
                  state_q <= S_STOP;
               end else begin
                  cnt_q <= cnt_q + 16'd1;
               end
            end
`endif
            S_STOP: begin
               if (tick_full) begin
                  cnt_q   <= 16'd0;
                  state_q <= S_IDLE;
               end else begin
                  cnt_q <= cnt_q + 16'd1;
               end
            end
            default: begin
               cnt_q   <= 16'd0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Bench for uart_rx_deserializer: directed frame table, hand sequences
// and random frames against a byte-level receive model.
module tb_uart_rx_deserializer;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        uart_rx_i;
   logic [15:0] cdiv_i;
   logic [7:0]  data_o;
   logic        valid_o;
   logic        ready_i;
   logic        frame_err_o;
   logic        overrun_o;
   logic        busy_o;
`ifdef UART_RX_PARITY_EN
   logic        parity_err_o;
`endif

   uart_rx_deserializer dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .uart_rx_i   (uart_rx_i),
      .cdiv_i      (cdiv_i),
      .data_o      (data_o),
      .valid_o     (valid_o),
      .ready_i     (ready_i),
      .frame_err_o (frame_err_o),
      .overrun_o   (overrun_o),
`ifdef UART_RX_PARITY_EN
      .parity_err_o(parity_err_o),
`endif
      .busy_o      (busy_o)
   );

   always #5 clk_i = ~clk_i;

   int tests = 0;
   int fails = 0;
   int fe_cnt, ov_cnt, pe_cnt, vhi_cnt, bsy_cnt;
   int wide_cnt = 0;
   logic fe_d = 1'b0;
   logic ov_d = 1'b0;
   logic pe_d = 1'b0;
   logic [7:0] got_q[$];
   logic [7:0] exp_q[$];

   always @(negedge clk_i) begin
      if (frame_err_o) fe_cnt++;
      if (overrun_o) ov_cnt++;
      if (valid_o) vhi_cnt++;
      if (busy_o) bsy_cnt++;
      if ((frame_err_o && fe_d) || (overrun_o && ov_d)) wide_cnt++;
      fe_d = frame_err_o;
      ov_d = overrun_o;
`ifdef UART_RX_PARITY_EN
      if (parity_err_o) pe_cnt++;
      if (parity_err_o && pe_d) wide_cnt++;
      pe_d = parity_err_o;
`endif
      if (valid_o && ready_i) got_q.push_back(data_o);
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic clr();
      fe_cnt = 0;
      ov_cnt = 0;
      pe_cnt = 0;
      vhi_cnt = 0;
      bsy_cnt = 0;
      got_q.delete();
      exp_q.delete();
   endtask

   function automatic int per_of(input logic [15:0] cd);
      return (cd < 16'd4) ? 4 : int'(cd);
   endfunction

   // One frame; cdiv_i is scrambled once the start bit is past, since
   // the receiver must only use the value seen at the start edge.
   task automatic send(input logic [7:0] d, input logic stop,
                       input logic par, input logic [15:0] cd);
      int per;
      per = per_of(cd);
      cdiv_i = cd;
      uart_rx_i = 1'b0;
      cyc(per);
      cdiv_i = 16'($urandom);
      for (int i = 0; i < 8; i++) begin
         uart_rx_i = d[i];
         cyc(per);
      end
`ifdef UART_RX_PARITY_EN
      uart_rx_i = par;
      cyc(per);
`else
      if (par) uart_rx_i = 1'b1;
`endif
      uart_rx_i = stop;
      cyc(per);
      uart_rx_i = 1'b1;
      cdiv_i = cd;
   endtask

   task automatic chk_bytes(input string nm);
      int bad;
      bad = 0;
      chk({nm, "_nbytes"}, got_q.size(), exp_q.size());
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
         if (got_q[i] != exp_q[i]) bad++;
      chk({nm, "_bytes"}, bad, 0);
   endtask

   typedef struct {
      logic [15:0] cdiv;
      logic [7:0]  d;
      logic        stop;
      int          exp_fe;
      int          exp_n;
      logic [7:0]  exp_d;
   } vec_t;

   vec_t vt[6];
   logic m_valid;
   logic [7:0] m_data;

   initial begin
      vt[0] = '{16'd16, 8'hA5, 1'b1, 0, 1, 8'hA5};
      vt[1] = '{16'd16, 8'h3C, 1'b0, 1, 0, 8'h00};
      vt[2] = '{16'd4,  8'h00, 1'b1, 0, 1, 8'h00};
      vt[3] = '{16'd5,  8'hFF, 1'b1, 0, 1, 8'hFF};
      vt[4] = '{16'd2,  8'h81, 1'b1, 0, 1, 8'h81};
      vt[5] = '{16'd19, 8'h6E, 1'b1, 0, 1, 8'h6E};

      rst_i = 1'b1;
      uart_rx_i = 1'b1;
      ready_i = 1'b1;
      cdiv_i = 16'd16;
      cyc(3);
      chk("rst_data", data_o, 0);
      chk("rst_valid", valid_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_fe", frame_err_o, 0);
      chk("rst_ov", overrun_o, 0);
      rst_i = 1'b0;
      cyc(4);

      // directed table
      for (int v = 0; v < 6; v++) begin
         logic [7:0] first;
         clr();
         ready_i = 1'b1;
         send(vt[v].d, vt[v].stop, ^vt[v].d, vt[v].cdiv);
         cyc(per_of(vt[v].cdiv) + 8);
         first = (got_q.size() > 0) ? got_q[0] : 8'h00;
         chk($sformatf("vec%0d_fe", v), fe_cnt, vt[v].exp_fe);
         chk($sformatf("vec%0d_ov", v), ov_cnt, 0);
         chk($sformatf("vec%0d_n", v), got_q.size(), vt[v].exp_n);
         chk($sformatf("vec%0d_d", v), first, vt[v].exp_d);
         chk($sformatf("vec%0d_vhi", v), vhi_cnt, vt[v].exp_n);
         chk($sformatf("vec%0d_busy", v), busy_o, 0);
      end

      // false start
      clr();
      uart_rx_i = 1'b0;
      cyc(5);
      uart_rx_i = 1'b1;
      cyc(40);
      chk("fs_entered", int'(bsy_cnt > 0), 1);
      chk("fs_busy", busy_o, 0);
      chk("fs_valid", vhi_cnt, 0);
      chk("fs_pulses", fe_cnt + ov_cnt + pe_cnt, 0);

      // back-to-back frames at minimum divider
      clr();
      ready_i = 1'b1;
      send(8'h12, 1'b1, ^8'h12, 16'd4);
      send(8'hC3, 1'b1, ^8'hC3, 16'd4);
      send(8'h7E, 1'b1, ^8'h7E, 16'd4);
      cyc(12);
      exp_q = '{8'h12, 8'hC3, 8'h7E};
      chk_bytes("b2b");

      // overrun with stalled consumer
      clr();
      ready_i = 1'b0;
      send(8'h11, 1'b1, ^8'h11, 16'd16);
      cyc(4);
      send(8'h22, 1'b1, ^8'h22, 16'd16);
      cyc(24);
      chk("ovr_data", data_o, 8'h11);
      chk("ovr_valid", valid_o, 1);
      chk("ovr_cnt", ov_cnt, 1);
      chk("ovr_fe", fe_cnt, 0);
      ready_i = 1'b1;
      cyc(1);
      ready_i = 1'b0;
      cyc(2);
      exp_q = '{8'h11};
      chk_bytes("ovr");
      chk("ovr_clear", valid_o, 0);

      // reset during bit 4
      clr();
      ready_i = 1'b1;
      cdiv_i = 16'd16;
      uart_rx_i = 1'b0;
      cyc(16);
      for (int i = 0; i < 4; i++) begin
         uart_rx_i = 1'((8'h5A >> i) & 8'h01);
         cyc(16);
      end
      uart_rx_i = 1'b1;
      cyc(5);
      rst_i = 1'b1;
      cyc(1);
      rst_i = 1'b0;
      chk("mid_rst_busy0", busy_o, 0);
      cyc(40);
      chk("mid_rst_busy", busy_o, 0);
      chk("mid_rst_valid", vhi_cnt, 0);
      chk("mid_rst_pulses", fe_cnt + ov_cnt + pe_cnt, 0);
      send(8'h5A, 1'b1, ^8'h5A, 16'd16);
      cyc(24);
      exp_q = '{8'h5A};
      chk_bytes("mid_rst");

      // line held low through and after reset
      uart_rx_i = 1'b0;
      rst_i = 1'b1;
      cyc(2);
      rst_i = 1'b0;
      clr();
      cyc(40);
      chk("low_rst_busy", bsy_cnt, 0);
      uart_rx_i = 1'b1;
      cyc(40);
      chk("low_rst_rise", bsy_cnt + fe_cnt, 0);

`ifdef UART_RX_PARITY_EN
      clr();
      send(8'h01, 1'b1, 1'b0, 16'd16);
      cyc(24);
      chk("par_bad_pe", pe_cnt, 1);
      chk("par_bad_valid", vhi_cnt, 0);
      clr();
      send(8'h01, 1'b1, 1'b1, 16'd16);
      cyc(24);
      chk("par_ok_pe", pe_cnt, 0);
      exp_q = '{8'h01};
      chk_bytes("par_ok");
`endif

      // random frames against the byte-level model
      rst_i = 1'b1;
      uart_rx_i = 1'b1;
      cyc(2);
      rst_i = 1'b0;
      cyc(4);
      m_valid = 1'b0;
      m_data = 8'h00;
      for (int n = 0; n < 40; n++) begin
         logic [15:0] cd;
         logic [7:0]  d;
         logic        stop, pbad, rdy;
         int          efe, eov, epe;
         cd = ($urandom % 8 == 0) ? 16'($urandom_range(0, 3))
                                  : 16'($urandom_range(4, 20));
         d = 8'($urandom);
         stop = ($urandom % 6) != 0;
`ifdef UART_RX_PARITY_EN
         pbad = ($urandom % 6) == 0;
`else
         pbad = 1'b0;
`endif
         rdy = 1'($urandom % 2);
         efe = 0;
         eov = 0;
         epe = 0;
         clr();
         ready_i = rdy;
         if (rdy && m_valid) begin
            exp_q.push_back(m_data);
            m_valid = 1'b0;
         end
         if (!stop) efe = 1;
         else if (pbad) epe = 1;
         else if (m_valid) eov = 1;
         else begin
            m_data = d;
            if (rdy) exp_q.push_back(d);
            else m_valid = 1'b1;
         end
         send(d, stop, (^d) ^ pbad, cd);
         cyc(per_of(cd) + 6);
         chk($sformatf("rnd%0d_fe", n), fe_cnt, efe);
         chk($sformatf("rnd%0d_ov", n), ov_cnt, eov);
`ifdef UART_RX_PARITY_EN
         chk($sformatf("rnd%0d_pe", n), pe_cnt, epe);
`else
         if (epe != 0) chk("rnd_pe_model", epe, 0);
`endif
         chk_bytes($sformatf("rnd%0d", n));
         chk($sformatf("rnd%0d_valid", n), valid_o, m_valid);
         chk($sformatf("rnd%0d_data", n), data_o, m_data);
      end

      chk("pulse_width", wide_cnt, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
